apb_cmd_master: RTL and testbench

Single-outstanding APB4 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns each completion on a valid/ready response stream. Sits directly upstream of the team's APB register slaves and drives their psel/penable/paddr/pwrite/pwdata/pstrb/pprot inputs. Adds an ACCESS-phase timeout so a non-responding slave cannot hang the command path.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_cmd_master.sv | 129 ++++++++++++
 tb/tb_apb_cmd_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions for the command master.
// State encoding and protection width.
package apb_pkg;

   localparam int PROT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 requester with ACCESS timeout.
// Command stream in, APB transfer out, response stream back.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic                    cmd_write,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic [PROT_W-1:0]       cmd_prot,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [PROT_W-1:0]       pprot,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic                    pready,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pslverr
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TEN = (TIMEOUT_CYCLES > 0);
   localparam logic [TW-1:0] TLAST =
      TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] tcnt;
   logic          accept;
   logic          expire;

   assign accept = cmd_valid & cmd_ready;
   assign expire = TEN & ~pready & (tcnt == TLAST);

   // State register.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; the wait timer only counts ACCESS cycles.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (accept) state_nxt = SETUP;
         SETUP:  state_nxt = ACCESS;
         ACCESS: if (pready | expire) state_nxt = RESP;
         RESP:   if (rsp_ready) state_nxt = IDLE;
      endcase
   end

   // Registered handshake and APB phase outputs, taken from next state.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cmd_ready <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         cmd_ready <= (state_nxt == IDLE);
         psel      <= (state_nxt == SETUP) | (state_nxt == ACCESS);
         penable   <= (state_nxt == ACCESS);
         rsp_valid <= (state_nxt == RESP);
      end
   end

   // Holding registers drive the APB bus; read data/strobes zeroed here.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         paddr  <= '0;
         pprot  <= '0;
         pwrite <= 1'b0;
         pwdata <= '0;
         pstrb  <= '0;
      end else if (state == IDLE && accept) begin
         paddr  <= cmd_addr;
         pprot  <= cmd_prot;
         pwrite <= cmd_write;
         pwdata <= cmd_write ? cmd_wdata : '0;
         pstrb  <= cmd_write ? cmd_strb : '0;
      end
   end

   // ACCESS wait timer, cleared while in SETUP.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tcnt <= '0;
      end else if (state == SETUP) begin
         tcnt <= '0;
      end else if (state == ACCESS && !pready && !expire) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Response capture: slave completion wins over a same-cycle expiry.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state == ACCESS) begin
         if (pready) begin
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
         end else if (expire) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master with a behavioural APB slave.
// Expected responses come from a simple register-file model.
module tb_apb_cmd_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic          cmd_write = 1'b0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_strb = '0;
   logic [2:0]    cmd_prot = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] paddr;
   logic [2:0]    pprot;
   logic          psel, penable, pwrite;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic          pready = 1'b0;
   logic [DW-1:0] prdata = '0;
   logic          pslverr = 1'b0;

   logic          n_cmd_valid = 1'b0;
   logic          n_cmd_ready;
   logic          n_rsp_valid;
   logic [DW-1:0] n_rsp_rdata;
   logic          n_rsp_err;
   logic [AW-1:0] n_paddr;
   logic [2:0]    n_pprot;
   logic          n_psel, n_penable, n_pwrite;
   logic [DW-1:0] n_pwdata;
   logic [SW-1:0] n_pstrb;

   apb_cmd_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
   ) u_dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_write(cmd_write),
      .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pprot(pprot), .psel(psel),
      .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   apb_cmd_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(0)
   ) u_nt (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready),
      .cmd_addr(32'h8), .cmd_write(1'b0),
      .cmd_wdata(32'h0), .cmd_strb(4'h0),
      .cmd_prot(3'h0),
      .rsp_valid(n_rsp_valid), .rsp_ready(1'b1),
      .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err),
      .paddr(n_paddr), .pprot(n_pprot), .psel(n_psel),
      .penable(n_penable), .pwrite(n_pwrite),
      .pwdata(n_pwdata), .pstrb(n_pstrb),
      .pready(1'b0), .prdata(32'h0), .pslverr(1'b0)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   exp_t sb[$];
   int   wq[$];
   logic [31:0] mmem[8];
   logic [31:0] smem[8];

   // Behavioural APB slave: 8 regs at 0x08.., per-transfer wait count.
   int          scnt = 0;
   logic [71:0] sbus;
   always @(negedge pclk) begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
      if (presetn && psel && !penable) begin
         scnt = (wq.size() > 0) ? wq.pop_front() : 0;
         sbus = {paddr, pwrite, pwdata, pstrb, pprot};
         if (!pwrite) chk("rd_pstrb_pwdata_zero", {pstrb, pwdata}, 0);
      end else if (presetn && psel && penable) begin
         chk("apb_stable", {paddr, pwrite, pwdata, pstrb, pprot}, sbus);
         if (scnt > 0) begin
            scnt--;
            pready = 1'b0;
         end else begin
            pready = 1'b1;
            if (paddr >= 8 && paddr < 40 && paddr[1:0] == 2'b00) begin
               pslverr = 1'b0;
               if (pwrite) begin
                  for (int b = 0; b < SW; b++)
                     if (pstrb[b])
                        smem[(paddr - 8) >> 2][8*b +: 8] = pwdata[8*b +: 8];
               end else begin
                  prdata = smem[(paddr - 8) >> 2];
               end
            end else begin
               pslverr = 1'b1;
            end
         end
      end
   end

   // Response monitor: pops the scoreboard and paces rsp_ready.
   bit          active = 0;
   exp_t        cur;
   logic [32:0] held;
   int          hold = 0;
   int          nresp = 0;
   always @(negedge pclk) begin
      if (!presetn) begin
         active = 0;
         rsp_ready = 1'b0;
      end else if (rsp_valid) begin
         if (!active) begin
            active = 1;
            held = {rsp_rdata, rsp_err};
            if (sb.size() == 0) begin
               chk("unexpected_rsp", {rsp_valid}, 0);
            end else begin
               cur = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, cur.rdata);
               chk("rsp_err", rsp_err, cur.err);
               chk("rsp_latency", cyc, cur.due);
               chk("bus_idle_in_resp", {psel, penable}, 0);
            end
            hold = (nresp == 5) ? 5 : $urandom_range(0, 2);
            nresp++;
         end else begin
            chk("rsp_stable", {rsp_rdata, rsp_err}, held);
         end
         chk("cmd_ready_low_in_resp", cmd_ready, 0);
         if (hold > 0) begin
            rsp_ready = 1'b0;
            hold--;
         end else begin
            rsp_ready = 1'b1;
            active = 0;
         end
      end else begin
         if (active) chk("rsp_dropped", rsp_valid, 1);
         active = 0;
         rsp_ready = 1'($urandom);
      end
   end

   // Issue one command and push the model's expected response.
   task automatic issue(input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int w, input bit want);
      exp_t e;
      int   n;
      bit   inr;
      int   idx;
      inr = (a >= 8) && (a < 40) && (a % 4 == 0);
      idx = inr ? (int'(a) - 8) / 4 : 0;
      e.rdata = 0;
      e.err = 0;
      if (w >= 16 || !inr) begin
         e.err = 1;
      end else if (wr) begin
         for (int b = 0; b < 4; b++)
            if (st[b]) mmem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         e.rdata = mmem[idx];
      end
      cmd_valid = 1'b1;
      cmd_addr = a;
      cmd_write = wr;
      cmd_wdata = wd;
      cmd_strb = st;
      cmd_prot = 3'($urandom);
      n = 0;
      while (!cmd_ready && n < 300) begin
         @(negedge pclk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", cmd_ready, 1);
         cmd_valid = 1'b0;
         return;
      end
      e.due = cyc + 1 + 2 + ((w >= 16) ? 15 : w);
      wq.push_back(w);
      if (want) sb.push_back(e);
      @(negedge pclk);
      cmd_valid = 1'b0;
      cmd_addr = $urandom;
      cmd_wdata = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() > 0 || rsp_valid || psel) && n < 1000) begin
         @(negedge pclk);
         n++;
      end
      chk("drain_done", sb.size(), 0);
   endtask

   logic [31:0] ra;
   int          r;
   int          w;
   bit          bad;

   initial begin
      for (int i = 0; i < 8; i++) begin
         mmem[i] = i;
         smem[i] = i;
      end
      #12;
      chk("reset_outputs",
          {cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable,
           pwrite, paddr, pwdata, pstrb, pprot}, 0);
      @(negedge pclk);
      presetn = 1'b1;

      @(negedge pclk);
      n_cmd_valid = 1'b1;
      r = 0;
      while (!n_cmd_ready && r < 20) begin
         @(negedge pclk);
         r++;
      end
      @(negedge pclk);
      n_cmd_valid = 1'b0;
      @(negedge pclk);
      bad = 0;
      repeat (100) begin
         @(negedge pclk);
         if (n_rsp_valid || !(n_psel && n_penable)) bad = 1;
      end
      chk("no_timeout_stuck", bad, 0);

      @(negedge pclk);
      issue(32'h0C, 0, 0, 0, 0, 1);
      issue(32'h08, 1, 32'h5, 4'hF, 0, 1);
      issue(32'h08, 0, 0, 0, 0, 1);
      issue(32'h100, 0, 0, 0, 0, 1);
      issue(32'h10, 0, 0, 0, 3, 1);
      issue(32'h14, 1, $urandom, 4'hF, 16, 1);
      issue(32'h14, 0, 0, 0, 15, 1);
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 9);
         ra = (r < 8) ? 32'(8 + 4 * r) : ((r == 8) ? 32'h100 : 32'h4);
         r = $urandom_range(0, 19);
         w = (r < 16) ? r % 5 : ((r == 16) ? 15 : ((r == 17) ? 16 : 20));
         issue(ra, 1'($urandom), $urandom, 4'($urandom), w, 1);
      end
      drain();

      issue(32'h18, 0, 0, 0, 40, 0);
      r = 0;
      while (!(psel && penable) && r < 20) begin
         @(negedge pclk);
         r++;
      end
      repeat (2) @(negedge pclk);
      #2 presetn = 1'b0;
      #1;
      chk("async_reset_outputs",
          {psel, penable, rsp_valid, cmd_ready}, 0);
      @(negedge pclk);
      presetn = 1'b1;
      repeat (40) @(negedge pclk);
      chk("no_rsp_after_reset", sb.size(), 0);
      issue(32'h0C, 0, 0, 0, 1, 1);
      issue(32'h1C, 0, 0, 0, 0, 1);
      drain();
      repeat (5) @(negedge pclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
